issue_queue: RTL and testbench

- In-order instruction issue front end for the reservation-station block (RS).
- Buffers decoded instructions from fetch/decode in a small FIFO.
- Presents the head entry to RS on its issue interface (unit, reg1, reg2, reg3, hasimm, imm, enable) and pops it only when RS answers out=1.
- RS returns out=0 when the target station bank is full; the entry is then held and retried after a back-off, never dropped.

---
 rtl/issue_queue_pkg.sv | 38 +++
 rtl/issue_queue_if.sv | 55 +++++
 rtl/issue_queue_fifo.sv | 75 +++++++
 rtl/issue_queue.sv | 162 ++++++++++++++++
 tb/tb_issue_queue.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/issue_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_pkg
// Purpose  : Shared unit codes, field widths, queue entry layout, FSM states.
// Revision : 1.0
// ============================================================================
package issue_queue_pkg;

  localparam int REG_W  = 6;
  localparam int WORD_W = 32;

  localparam logic [2:0] UNIT_LW  = 3'b000;
  localparam logic [2:0] UNIT_SW  = 3'b001;
  localparam logic [2:0] UNIT_ADD = 3'b010;
  localparam logic [2:0] UNIT_MUL = 3'b011;
  localparam logic [2:0] UNIT_MV  = 3'b100;

  typedef struct packed {
    logic [2:0]        unit;
    logic              hasimm;
    logic [REG_W-1:0]  reg1;
    logic [REG_W-1:0]  reg2;
    logic [REG_W-1:0]  reg3;
    logic [WORD_W-1:0] imm;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RETRY = 2'd2
  } state_t;

  function automatic logic unit_legal(input logic [2:0] unit);
    return unit <= UNIT_MV;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue_if
// Purpose  : Decode-side push port, RS issue port and status of the issue
//            queue. ISSUE_STATS_EN adds the saturating statistics outputs.
// Revision : 1.0
// ============================================================================
interface issue_queue_if #(parameter int DEPTH = 8);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                                flush;
  logic                                in_valid;
  logic                                in_ready;
  logic [2:0]                          in_unit;
  logic [issue_queue_pkg::REG_W-1:0]   in_reg1;
  logic [issue_queue_pkg::REG_W-1:0]   in_reg2;
  logic [issue_queue_pkg::REG_W-1:0]   in_reg3;
  logic                                in_hasimm;
  logic [issue_queue_pkg::WORD_W-1:0]  in_imm;

  logic [2:0]                          unit;
  logic [issue_queue_pkg::REG_W-1:0]   reg1;
  logic [issue_queue_pkg::REG_W-1:0]   reg2;
  logic [issue_queue_pkg::REG_W-1:0]   reg3;
  logic                                hasimm;
  logic [issue_queue_pkg::WORD_W-1:0]  imm;
  logic                                enable;
  logic                                out;
  logic                                illegal;
  logic [CNT_W-1:0]                    count;
`ifdef ISSUE_STATS_EN
  logic [31:0]                         stat_issued;
  logic [31:0]                         stat_rejects;
  logic [31:0]                         stat_stall;
`endif

  modport master (
    output flush, in_valid, in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm, out,
    input  in_ready, unit, reg1, reg2, reg3, hasimm, imm, enable, illegal, count
`ifdef ISSUE_STATS_EN
    , input stat_issued, stat_rejects, stat_stall
`endif
  );

  modport slave (
    input  flush, in_valid, in_unit, in_reg1, in_reg2, in_reg3, in_hasimm, in_imm, out,
    output in_ready, unit, reg1, reg2, reg3, hasimm, imm, enable, illegal, count
`ifdef ISSUE_STATS_EN
    , output stat_issued, stat_rejects, stat_stall
`endif
  );

endinterface
`default_nettype wire

// File: rtl/issue_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module   : issue_fifo
// Purpose  : Synchronous FIFO of queue entries with count/full/empty and a
//            peek at the entry behind the head.
// Revision : 1.0
// ============================================================================
module issue_fifo
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           head,
  output entry_t           next_head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign next_head = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Purpose  : In-order issue front end to RS: FIFO, issue/retry FSM with
//            back-off, illegal-unit filter. ISSUE_STATS_EN adds counters.
// Revision : 1.0
// ============================================================================
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int BACKOFF = 2
) (
  input  logic          clk,
  input  logic          rst,
  issue_queue_if.slave  q
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int BO_W  = $clog2(BACKOFF + 1);

  entry_t           in_entry, head, next_head, follow;
  entry_t           fields_q, fields_d;
  state_t           state_q, state_d;
  logic             enable_q, enable_d;
  logic             illegal_q, illegal_d;
  logic [BO_W-1:0]  bo_q, bo_d;
  logic             push, pop, full, empty, remain;
  logic [CNT_W-1:0] count;

  assign in_entry = '{unit: q.in_unit, hasimm: q.in_hasimm, reg1: q.in_reg1,
                      reg2: q.in_reg2, reg3: q.in_reg3, imm: q.in_imm};
  assign push     = q.in_valid && !full;

  issue_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clr       (q.flush),
    .push      (push),
    .wdata     (in_entry),
    .pop       (pop),
    .head      (head),
    .next_head (next_head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // After an accept the next head is the second entry, or the entry being
  // pushed this very cycle when only one was stored.
  assign remain = (count > CNT_W'(1)) || push;
  assign follow = (count > CNT_W'(1)) ? next_head : in_entry;

  always_comb begin
    state_d   = state_q;
    enable_d  = 1'b0;
    illegal_d = 1'b0;
    fields_d  = fields_q;
    bo_d      = bo_q;
    pop       = 1'b0;
    if (q.flush) begin
      state_d = ST_EMPTY;
      bo_d    = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (!empty) begin
            if (!unit_legal(head.unit)) begin
              pop       = 1'b1;
              illegal_d = 1'b1;
            end else begin
              state_d  = ST_ISSUE;
              enable_d = 1'b1;
              fields_d = head;
            end
          end
        end
        ST_ISSUE: begin
          if (q.out) begin
            pop = 1'b1;
            // An illegal follower is left for EMPTY to discard.
            if (remain && unit_legal(follow.unit)) begin
              enable_d = 1'b1;
              fields_d = follow;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            state_d = ST_RETRY;
            bo_d    = BO_W'(BACKOFF);
          end
        end
        ST_RETRY: begin
          bo_d = bo_q - BO_W'(1);
          if (bo_q == BO_W'(1)) begin
            state_d  = ST_ISSUE;
            enable_d = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      enable_q  <= 1'b0;
      illegal_q <= 1'b0;
      fields_q  <= '0;
      bo_q      <= '0;
    end else begin
      state_q   <= state_d;
      enable_q  <= enable_d;
      illegal_q <= illegal_d;
      fields_q  <= fields_d;
      bo_q      <= bo_d;
    end
  end

  assign q.in_ready = !full;
  assign q.unit     = fields_q.unit;
  assign q.hasimm   = fields_q.hasimm;
  assign q.reg1     = fields_q.reg1;
  assign q.reg2     = fields_q.reg2;
  assign q.reg3     = fields_q.reg3;
  assign q.imm      = fields_q.imm;
  assign q.enable   = enable_q;
  assign q.illegal  = illegal_q;
  assign q.count    = count;

`ifdef ISSUE_STATS_EN
  logic [31:0] issued_q, issued_d, rejects_q, rejects_d, stall_q, stall_d;

  always_comb begin
    issued_d  = issued_q;
    rejects_d = rejects_q;
    stall_d   = stall_q;
    if (enable_q && q.out && (issued_q != '1))   issued_d  = issued_q + 32'd1;
    if (enable_q && !q.out && (rejects_q != '1)) rejects_d = rejects_q + 32'd1;
    if ((state_q == ST_RETRY) && (stall_q != '1)) stall_d  = stall_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q  <= '0;
      rejects_q <= '0;
      stall_q   <= '0;
    end else begin
      issued_q  <= issued_d;
      rejects_q <= rejects_d;
      stall_q   <= stall_d;
    end
  end

  assign q.stat_issued  = issued_q;
  assign q.stat_rejects = rejects_q;
  assign q.stat_stall   = stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_queue
// Purpose  : Directed self-checking bench for issue_queue with an issue
//            scoreboard.
// Revision : 1.0
// ============================================================================
module tb_issue_queue;
  import issue_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_queue_if #(.DEPTH(8)) bus ();

  issue_queue #(.DEPTH(8), .BACKOFF(2)) dut (
    .clk (clk),
    .rst (rst),
    .q   (bus)
  );

  int     checks       = 0;
  int     errors       = 0;
  int     illegal_seen = 0;
  entry_t exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the offer until the queue takes it; legal entries go to the scoreboard.
  task automatic push_one(input logic [2:0] u, input logic [5:0] a, input logic [5:0] b,
                          input logic [5:0] c, input logic h, input logic [31:0] im);
    int n = 0;
    bit done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_unit   = u;
    bus.in_reg1   = a;
    bus.in_reg2   = b;
    bus.in_reg3   = c;
    bus.in_hasimm = h;
    bus.in_imm    = im;
    while (!done && n < 60) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        if (u <= UNIT_MV) exp_q.push_back('{unit: u, hasimm: h, reg1: a, reg2: b, reg3: c, imm: im});
      end
      tick();
      n++;
    end
    chk("push_accepted", 64'(done), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while ((bus.count != 0 || bus.enable) && n < max) begin
      tick();
      n++;
    end
    chk("drain_in_time", 64'(n < max), 64'd1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.illegal) illegal_seen++;
      if (bus.enable) begin
        chk("enable_unit_legal", 64'(bus.unit > UNIT_MV), 64'd0);
        if (bus.out) begin
          chk("issue_expected", 64'(exp_q.size() != 0), 64'd1);
          if (exp_q.size() != 0) begin
            entry_t e;
            e = exp_q.pop_front();
            chk("issue_fields", 64'({bus.unit, bus.hasimm, bus.reg1, bus.reg2, bus.reg3, bus.imm}),
                64'(e));
          end
        end
      end
    end
  end

  initial begin
    int base;
`ifdef ISSUE_STATS_EN
    logic [31:0] s_iss, s_rej, s_stl;
`endif
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_unit = '0; bus.in_reg1 = '0;
    bus.in_reg2 = '0; bus.in_reg3 = '0; bus.in_hasimm = 1'b0; bus.in_imm = '0; bus.out = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_enable", 64'(bus.enable), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_illegal", 64'(bus.illegal), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_fields", 64'({bus.unit, bus.reg1, bus.imm}), 64'd0);
    rst = 1'b0;

    // Single add, always accepted
    push_one(UNIT_ADD, 6'd1, 6'd2, 6'd3, 1'b0, 32'd0);
    chk("t1_count_after_push", 64'(bus.count), 64'd1);
    chk("t1_enable_latency", 64'(bus.enable), 64'd0);
    tick();
    chk("t1_enable_on", 64'(bus.enable), 64'd1);
    chk("t1_unit", 64'(bus.unit), 64'(UNIT_ADD));
    chk("t1_reg3", 64'(bus.reg3), 64'd3);
    tick();
    chk("t1_enable_off", 64'(bus.enable), 64'd0);
    chk("t1_count_drained", 64'(bus.count), 64'd0);

    // Fill to full while RS refuses, 9th held off
    bus.out = 1'b0;
    for (int i = 0; i < 8; i++)
      push_one(UNIT_MUL, 6'(i), 6'(i + 1), 6'(i + 2), 1'(i), 32'(i * 100));
    chk("t2_count_full", 64'(bus.count), 64'd8);
    chk("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b1; bus.in_unit = UNIT_MV; bus.in_reg1 = 6'd40; bus.in_reg2 = 6'd41;
    bus.in_reg3 = 6'd42; bus.in_hasimm = 1'b1; bus.in_imm = 32'h1234_5678;
    repeat (3) tick();
    chk("t2_ninth_held", 64'(bus.count), 64'd8);
    bus.out = 1'b1;
    push_one(UNIT_MV, 6'd40, 6'd41, 6'd42, 1'b1, 32'h1234_5678);
    wait_empty(60);
    chk("t2_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Reject then retry after back-off
`ifdef ISSUE_STATS_EN
    s_iss = bus.stat_issued; s_rej = bus.stat_rejects; s_stl = bus.stat_stall;
`endif
    bus.out = 1'b0;
    push_one(UNIT_ADD, 6'd4, 6'd5, 6'd6, 1'b1, 32'hFFFF_FFF9);
    chk("t3_pre", 64'(bus.enable), 64'd0);
    tick();
    chk("t3_first_try", 64'(bus.enable), 64'd1);
    tick();
    chk("t3_backoff1", 64'(bus.enable), 64'd0);
    bus.out = 1'b1;
    tick();
    chk("t3_backoff2", 64'(bus.enable), 64'd0);
    tick();
    chk("t3_retry", 64'(bus.enable), 64'd1);
    chk("t3_retry_imm", 64'(bus.imm), 64'hFFFF_FFF9);
    chk("t3_retry_reg1", 64'(bus.reg1), 64'd4);
    tick();
    chk("t3_done", 64'(bus.enable), 64'd0);
    chk("t3_count", 64'(bus.count), 64'd0);
`ifdef ISSUE_STATS_EN
    chk("t3_stat_rejects", 64'(bus.stat_rejects - s_rej), 64'd1);
    chk("t3_stat_stall", 64'(bus.stat_stall - s_stl), 64'd2);
    chk("t3_stat_issued", 64'(bus.stat_issued - s_iss), 64'd1);
`endif

    // Illegal head discarded, following mul issued
    base = illegal_seen;
    push_one(3'b110, 6'd20, 6'd21, 6'd22, 1'b0, 32'd9);
    push_one(UNIT_MUL, 6'd7, 6'd8, 6'd9, 1'b0, 32'd5);
    wait_empty(20);
    chk("t4_illegal_pulses", 64'(illegal_seen - base), 64'd1);
    chk("t4_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Flush with a simultaneous push
    bus.out = 1'b0;
    for (int i = 0; i < 3; i++) push_one(UNIT_ADD, 6'(10 + i), 6'd0, 6'd0, 1'b0, 32'd0);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_unit = UNIT_SW;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    exp_q.delete();
    chk("t5_count", 64'(bus.count), 64'd0);
    chk("t5_enable", 64'(bus.enable), 64'd0);
    tick();
    chk("t5_push_dropped", 64'(bus.count), 64'd0);
    chk("t5_enable_stays", 64'(bus.enable), 64'd0);

    // Asynchronous reset in RETRY, then normal issue
    push_one(UNIT_ADD, 6'd10, 6'd11, 6'd12, 1'b0, 32'd1);
    tick();
    chk("t6_issue", 64'(bus.enable), 64'd1);
    tick();
    chk("t6_in_retry", 64'(bus.enable), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_count", 64'(bus.count), 64'd0);
    chk("t6_async_enable", 64'(bus.enable), 64'd0);
`ifdef ISSUE_STATS_EN
    chk("t6_stats_cleared", 64'(bus.stat_issued | bus.stat_rejects | bus.stat_stall), 64'd0);
`endif
    exp_q.delete();
    #2 rst = 1'b0;
    bus.out = 1'b1;
    tick();
    push_one(UNIT_LW, 6'd30, 6'd31, 6'd32, 1'b1, 32'd77);
    chk("t6_post_count", 64'(bus.count), 64'd1);
    tick();
    chk("t6_post_enable", 64'(bus.enable), 64'd1);
    tick();
    chk("t6_post_done", 64'(bus.count), 64'd0);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
